// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave view; the byte source / memory side takes the master view.
interface instr_loader_if #(
   parameter int ADDR_WIDTH = 9
) ();
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [15:0]           mem_wdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/instr_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory with big-endian
// 16-bit words from address 0 and holds the CPU stopped until the image is complete.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_LEN_HI  | waiting for length high byte
// S_LEN_LO  | waiting for length low byte; decides empty / oversized / load
// S_WORD_HI | waiting for high byte of the next word
// S_WORD_LO | waiting for low byte; acceptance issues the memory write
// S_DONE    | image complete, cpu_run follows one edge later
// S_ERROR   | header length exceeded DEPTH; nothing is written
module instr_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  restart,
   instr_loader_if.slave         bus,
   output logic [ADDR_WIDTH:0]   load_count,
   output logic                  cpu_run,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_WORD_HI,
      S_WORD_LO,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [15:0]           DEPTH_16 = 16'(DEPTH);

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [7:0]            word_hi_q, word_hi_d;
   logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]           mem_wdata_q, mem_wdata_d;
   logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
   logic                  cpu_run_q, cpu_run_d;
   logic                  error_q, error_d;

   logic                  in_ready_c;
   logic                  accept;
   logic [15:0]           len_full;
   logic                  last_word;

   assign len_full  = {len_hi_q, bus.in_data};
   assign last_word = (words_left_q == CNT_ONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_LEN_HI;
         len_hi_q     <= '0;
         word_hi_q    <= '0;
         words_left_q <= '0;
         idx_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         load_count_q <= '0;
         cpu_run_q    <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_hi_q     <= len_hi_d;
         word_hi_q    <= word_hi_d;
         words_left_q <= words_left_d;
         idx_q        <= idx_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         load_count_q <= load_count_d;
         cpu_run_q    <= cpu_run_d;
         error_q      <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = S_LEN_HI;
      end else begin
         case (state_q)
            S_LEN_HI:  if (accept) state_d = S_LEN_LO;
            S_LEN_LO: begin
               if (accept) begin
                  if (len_full == 16'd0)       state_d = S_DONE;
                  else if (len_full > DEPTH_16) state_d = S_ERROR;
                  else                          state_d = S_WORD_HI;
               end
            end
            S_WORD_HI: if (accept) state_d = S_WORD_LO;
            S_WORD_LO: if (accept) state_d = last_word ? S_DONE : S_WORD_HI;
            S_DONE:    state_d = S_DONE;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_LEN_HI;
         endcase
      end
   end

   always_comb begin
      in_ready_c   = 1'b0;
      len_hi_d     = len_hi_q;
      word_hi_d    = word_hi_q;
      words_left_d = words_left_q;
      idx_d        = idx_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      load_count_d = load_count_q;

      case (state_q)
         S_LEN_HI, S_LEN_LO, S_WORD_HI, S_WORD_LO: in_ready_c = !restart;
         default:                                  in_ready_c = 1'b0;
      endcase
      accept = bus.in_valid && in_ready_c;

      // status flags trail the state by one edge and drop on the restart edge
      cpu_run_d = (state_q == S_DONE)  && !restart;
      error_d   = (state_q == S_ERROR) && !restart;

      if (restart) load_count_d = '0;

      if (accept) begin
         case (state_q)
            S_LEN_HI:  len_hi_d = bus.in_data;
            S_LEN_LO: begin
               words_left_d = len_full[ADDR_WIDTH:0];
               idx_d        = '0;
               load_count_d = '0;
            end
            S_WORD_HI: word_hi_d = bus.in_data;
            S_WORD_LO: begin
               mem_we_d     = 1'b1;
               mem_addr_d   = idx_q;
               mem_wdata_d  = {word_hi_q, bus.in_data};
               idx_d        = idx_q + ADDR_ONE;
               words_left_d = words_left_q - CNT_ONE;
               load_count_d = load_count_q + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign load_count    = load_count_q;
   assign cpu_run       = cpu_run_q;
   assign error         = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: images are driven byte by byte and the
// observed write log and status are compared with a parse of the same byte list.
`timescale 1ns/1ps
module tb_instr_loader;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   typedef logic [7:0] bytes_t[$];

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          restart = 1'b0;
   logic [AW:0]   load_count;
   logic          cpu_run;
   logic          error;

   instr_loader_if #(.ADDR_WIDTH(AW)) bus ();

   instr_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .restart    (restart),
      .bus        (bus),
      .load_count (load_count),
      .cpu_run    (cpu_run),
      .error      (error)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // observed write log
   int     log_addr[$];
   int     log_data[$];
   longint log_time[$];
   longint run_rise = -1;
   logic   run_prev = 1'b0;
   longint last_acc = 0;

   always @(posedge clock) begin
      #1;
      if (bus.mem_we === 1'b1) begin
         log_addr.push_back(int'(bus.mem_addr));
         log_data.push_back(int'(bus.mem_wdata));
         log_time.push_back($time - 1);
      end
      if (cpu_run === 1'b1 && run_prev !== 1'b1) run_rise = $time - 1;
      run_prev = cpu_run;
   end

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_time.delete();
      run_rise = -1;
   endtask

   // reference: parse the byte list the way the stream format defines it
   int exp_addr[$];
   int exp_data[$];
   bit exp_done, exp_err;
   int exp_cnt, exp_len;

   function automatic void model(input bytes_t s);
      int nw;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_cnt  = 0;
      exp_len  = -1;
      if (s.size() < 2) return;
      exp_len = int'(s[0]) * 256 + int'(s[1]);
      if (exp_len > DEPTH) begin
         exp_err = 1;
         return;
      end
      nw = (s.size() - 2) / 2;
      if (nw > exp_len) nw = exp_len;
      for (int i = 0; i < nw; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back(int'(s[2 + 2 * i]) * 256 + int'(s[3 + 2 * i]));
      end
      exp_cnt  = nw;
      exp_done = (nw == exp_len);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 100 && !ok; t++) begin
         #1;
         if (bus.in_ready === 1'b1) begin
            ok = 1;
            @(posedge clock);
            last_acc = $time;
            @(negedge clock);
         end else begin
            @(negedge clock);
         end
      end
      bus.in_valid = 1'b0;
      chk("byte_accepted", 64'(ok), 64'd1);
   endtask

   task automatic send_image(input bytes_t s, input int min_gap, input int max_gap);
      for (int i = 0; i < s.size(); i++) begin
         if (i > 0) begin
            int gap;
            gap = int'($urandom_range(max_gap, min_gap));
            repeat (gap) begin
               bus.in_valid = 1'b0;
               bus.in_data  = 8'($urandom);
               @(negedge clock);
            end
         end
         send_byte(s[i]);
      end
   endtask

   task automatic verify(input string tag, input bytes_t s);
      int n;
      model(s);
      repeat (2) @(negedge clock);
      #1;
      chk({tag, "_nwrites"}, 64'(log_addr.size()), 64'(exp_addr.size()));
      n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, 64'(log_addr[i]), 64'(exp_addr[i]));
         chk({tag, "_data"}, 64'(log_data[i]), 64'(exp_data[i]));
      end
      chk({tag, "_load_count"}, 64'(load_count), 64'(exp_cnt));
      chk({tag, "_cpu_run"}, 64'(cpu_run), 64'(exp_done));
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(!(exp_done || exp_err)));
      if (exp_done && exp_cnt > 0 && log_time.size() > 0)
         chk({tag, "_run_after_write"}, 64'(run_rise - log_time[log_time.size() - 1]), 64'd10);
      if (exp_done && exp_len == 0)
         chk({tag, "_run_after_hdr"}, 64'(run_rise - last_acc), 64'd10);
   endtask

   task automatic do_restart();
      @(negedge clock);
      restart      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      #1;
      chk("ready_during_restart", 64'(bus.in_ready), 64'd0);
      @(negedge clock);
      restart      = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("restart_load_count", 64'(load_count), 64'd0);
      chk("restart_cpu_run", 64'(cpu_run), 64'd0);
      chk("restart_error", 64'(error), 64'd0);
      chk("restart_in_ready", 64'(bus.in_ready), 64'd1);
      clear_log();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      chk({tag, "_load_count"}, 64'(load_count), 64'd0);
      chk({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
      chk({tag, "_error"}, 64'(error), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bytes_t img;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      #2;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      clear_log();

      // back-to-back three-word image
      img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      send_image(img, 0, 0);
      verify("img3", img);
      for (int i = 1; i < log_time.size(); i++)
         chk("img3_spacing", 64'(log_time[i] - log_time[i - 1]), 64'd20);

      do_restart();
      img = '{8'h00, 8'h00};
      send_image(img, 0, 0);
      verify("empty", img);

      do_restart();
      img = '{8'h02, 8'h01};
      send_image(img, 0, 0);
      verify("oversize", img);
      do_restart();
      img = '{8'h00, 8'h01, 8'hAB, 8'hCD};
      send_image(img, 0, 0);
      verify("after_err", img);

      do_restart();
      img = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_image(img, 1, 3);
      verify("gaps", img);

      do_restart();
      img = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
      send_image(img, 0, 0);
      verify("partial", img);
      do_restart();
      img = '{8'h00, 8'h01, 8'h55, 8'h66};
      send_image(img, 0, 0);
      verify("after_partial", img);

      for (int r = 0; r < 6; r++) begin
         int len;
         do_restart();
         len = int'($urandom_range(24, 1));
         img = '{};
         img.push_back(8'(len >> 8));
         img.push_back(8'(len));
         for (int i = 0; i < 2 * len; i++) img.push_back(8'($urandom));
         send_image(img, 0, 2);
         verify("rand", img);
      end

      do_restart();
      begin
         int len;
         len = int'($urandom_range(65535, DEPTH + 1));
         img = '{};
         img.push_back(8'(len >> 8));
         img.push_back(8'(len));
         send_image(img, 0, 2);
         verify("rand_oversize", img);
      end

      // asynchronous reset in the middle of a word
      do_restart();
      img = '{8'h00, 8'h05, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'h77};
      send_image(img, 0, 0);
      verify("pre_reset", img);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      clear_log();

      img = '{8'h02, 8'h00};
      for (int i = 0; i < 2 * DEPTH; i++) img.push_back(8'($urandom));
      send_image(img, 0, 0);
      verify("full", img);
      if (log_addr.size() > 0)
         chk("full_last_addr", 64'(log_addr[log_addr.size() - 1]), 64'(DEPTH - 1));
      chk("full_load_count", 64'(load_count), 64'(DEPTH));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
